// File: rtl/mppt_sequencer.sv
// MPPT sample-and-step scheduler: interleaves V/I conversions on one shared ADC,
// averages 2^AVG_LOG2 pairs, strobes the tracker, then settles before the next round.
module mppt_sequencer #(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable,
  input  logic [15:0]      settle_cycles,
  output logic             adc_start,
  output logic             adc_ch,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_data,
  output logic             mppt_step,
  input  logic             mppt_ack,
  output logic [ADC_W-1:0] v_avg,
  output logic [ADC_W-1:0] i_avg,
  output logic             error,
  output logic             busy
);

  localparam int ACC_W  = ADC_W + AVG_LOG2;
  localparam int PAIR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, START_V, WAIT_V, START_I, WAIT_I, STEP, WAIT_ACK
  } state_t;

  state_t              state;
  logic [15:0]         settle_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [PAIR_W-1:0]   pair_cnt;
  logic [ACC_W-1:0]    v_acc, i_acc;
  logic [ACC_W-1:0]    v_sum, i_sum;
  logic                waiting, timeout_hit, abort;

  assign v_sum       = v_acc + ACC_W'(adc_data);
  assign i_sum       = i_acc + ACC_W'(adc_data);
  assign waiting     = (state == WAIT_V) || (state == WAIT_I);
  assign timeout_hit = waiting && !adc_done && (tmo_cnt == TMO_LAST);
  // Disable and ADC timeout share one teardown path; only timeout (with enable high) flags error.
  assign abort       = ((state != IDLE) && !enable) || timeout_hit;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      // NOTE: accumulators and counters are plain registers, so they take the reset too;
      // a round must never start from leftover partial sums.
      state      <= IDLE;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      pair_cnt   <= '0;
      v_acc      <= '0;
      i_acc      <= '0;
      adc_start  <= 1'b0;
      adc_ch     <= 1'b0;
      mppt_step  <= 1'b0;
      v_avg      <= '0;
      i_avg      <= '0;
      error      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: every state register here uses <= so all of them see pre-edge values.
      adc_start <= 1'b0;
      mppt_step <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        tmo_cnt  <= '0;
        pair_cnt <= '0;
        v_acc    <= '0;
        i_acc    <= '0;
        if (enable) error <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (!enable) begin
              error <= 1'b0;
            end else if (!error) begin
              state      <= SETTLE;
              settle_cnt <= settle_cycles;
              busy       <= 1'b1;
            end
          end
          SETTLE: begin
            if (settle_cnt == '0) begin
              state     <= START_V;
              adc_start <= 1'b1;
              adc_ch    <= 1'b0;
            end else begin
              settle_cnt <= settle_cnt - 16'd1;
            end
          end
          START_V: begin
            state   <= WAIT_V;
            tmo_cnt <= '0;
          end
          WAIT_V: begin
            if (adc_done) begin
              v_acc     <= v_sum;
              state     <= START_I;
              adc_start <= 1'b1;
              adc_ch    <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          START_I: begin
            state   <= WAIT_I;
            tmo_cnt <= '0;
          end
          WAIT_I: begin
            if (adc_done) begin
              if (pair_cnt == PAIR_LAST) begin
                // Averages are registered on entry so they are valid alongside mppt_step.
                state     <= STEP;
                mppt_step <= 1'b1;
                v_avg     <= ADC_W'(v_acc >> AVG_LOG2);
                i_avg     <= ADC_W'(i_sum >> AVG_LOG2);
                v_acc     <= '0;
                i_acc     <= '0;
                pair_cnt  <= '0;
              end else begin
                i_acc     <= i_sum;
                pair_cnt  <= pair_cnt + PAIR_W'(1);
                state     <= START_V;
                adc_start <= 1'b1;
                adc_ch    <= 1'b0;
              end
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          STEP, WAIT_ACK: begin
            if (mppt_ack) begin
              state      <= SETTLE;
              settle_cnt <= settle_cycles;
            end else begin
              state <= WAIT_ACK;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mppt_sequencer.sv
// Self-checking bench for mppt_sequencer: ADC and tracker models, scoreboard of
// expected averages popped on each mppt_step, scenario tasks with inline checks.
module tb_mppt_sequencer;

  localparam int ADC_W    = 12;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 255;

  typedef struct packed {
    logic [ADC_W-1:0] v;
    logic [ADC_W-1:0] i;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [15:0]      settle_cycles = 16'd0;
  logic             adc_start, adc_ch;
  logic             adc_done = 1'b0;
  logic [ADC_W-1:0] adc_data = '0;
  logic             mppt_step;
  logic             mppt_ack = 1'b0;
  logic [ADC_W-1:0] v_avg, i_avg;
  logic             error, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Monitor state
  int  start_count = 0, last_start_cyc = 0, step_count = 0, last_step_cyc = 0;
  bit  last_start_ch = 1'b0;
  exp_t sb[$];
  logic [ADC_W-1:0] held_v = '0, held_i = '0;

  // Tracker model
  int ack_delay = 0, ack_wait = 0, ack_cyc = 0;
  bit ack_pend = 1'b0;

  // ADC model
  bit adc_on = 1'b1;
  int adc_lat = 3, adc_cnt = 0;
  bit adc_pend_ch = 1'b0;
  logic [ADC_W-1:0] def_v = 12'h800, def_i = 12'h100;
  logic [ADC_W-1:0] vq[$], iq[$];

  mppt_sequencer #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .enable        (enable),
    .settle_cycles (settle_cycles),
    .adc_start     (adc_start),
    .adc_ch        (adc_ch),
    .adc_done      (adc_done),
    .adc_data      (adc_data),
    .mppt_step     (mppt_step),
    .mppt_ack      (mppt_ack),
    .v_avg         (v_avg),
    .i_avg         (i_avg),
    .error         (error),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ADC: done pulse adc_lat cycles after a start; data is random noise unless done.
  always @(negedge clk) begin
    adc_done = 1'b0;
    adc_data = ADC_W'($urandom);
    if (adc_cnt > 0) begin
      adc_cnt--;
      if (adc_cnt == 0) begin
        adc_done = 1'b1;
        if (!adc_pend_ch) adc_data = (vq.size() > 0) ? vq.pop_front() : def_v;
        else              adc_data = (iq.size() > 0) ? iq.pop_front() : def_i;
      end
    end
    if (!rst && adc_start && adc_on) begin
      adc_cnt     = adc_lat;
      adc_pend_ch = adc_ch;
    end
  end

  // Monitor, scoreboard and tracker ack.
  always @(negedge clk) begin
    exp_t e;
    mppt_ack = 1'b0;
    if (ack_pend) begin
      if (ack_wait == 0) begin
        mppt_ack = 1'b1;
        ack_pend = 1'b0;
        ack_cyc  = cyc;
      end else ack_wait--;
    end
    if (!rst && adc_start) begin
      start_count++;
      last_start_cyc = cyc;
      last_start_ch  = adc_ch;
    end
    if (!rst && mppt_step) begin
      step_count++;
      last_step_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step: v_avg=%0d i_avg=%0d, required no step", v_avg, i_avg);
      end else begin
        e = sb.pop_front();
        if (v_avg !== e.v || i_avg !== e.i) begin
          errors++;
          $display("FAIL step_avg: v_avg=%0d i_avg=%0d, required v=%0d i=%0d", v_avg, i_avg, e.v, e.i);
        end
        held_v = e.v;
        held_i = e.i;
      end
      if (ack_delay == 0) begin
        mppt_ack = 1'b1;
        ack_cyc  = cyc;
      end else begin
        ack_pend = 1'b1;
        ack_wait = ack_delay - 1;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic run_until_step(input int budget, output bit got);
    int base = step_count;
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (step_count != base) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_start(input int budget, output bit got);
    int base = start_count;
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (start_count != base) begin got = 1'b1; break; end
    end
  endtask

  task automatic quiesce;
    enable = 1'b0;
    repeat (8) tick();
    vq.delete();
    iq.delete();
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({adc_start, adc_ch, mppt_step, error, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got=%b required=00000", {adc_start, adc_ch, mppt_step, error, busy});
    end
    checks++;
    if (v_avg !== '0 || i_avg !== '0) begin
      errors++;
      $display("FAIL reset_avg: v_avg=%0d i_avg=%0d required 0/0", v_avg, i_avg);
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || adc_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b adc_start=%b required 0/0", busy, adc_start);
    end
  endtask

  task automatic test_basic_round;
    int c, n, step_rel, base_s, base_p;
    int rel[8];
    bit chs[8];
    settle_cycles = 16'd0;
    adc_lat = 3;
    ack_delay = 0;
    def_v = 12'h800;
    def_i = 12'h100;
    sb.push_back('{v: 12'h800, i: 12'h100});
    n = 0; step_rel = -1; base_s = start_count; base_p = step_count;
    c = cyc;
    enable = 1'b1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (start_count != base_s + n && n < 8) begin
        rel[n] = last_start_cyc - c;
        chs[n] = last_start_ch;
        n++;
      end
      if (step_count != base_p) begin
        step_rel = last_step_cyc - c;
        enable = 1'b0;
        break;
      end
    end
    checks++;
    if (start_count - base_s != 8) begin
      errors++;
      $display("FAIL basic_start_count: got=%0d required=8", start_count - base_s);
    end
    for (int j = 0; j < n; j++) begin
      checks++;
      if (rel[j] != 2 + 4 * j || chs[j] != j[0]) begin
        errors++;
        $display("FAIL basic_start_%0d: cycle=%0d ch=%0d required cycle=%0d ch=%0d",
                 j, rel[j], chs[j], 2 + 4 * j, j[0]);
      end
    end
    checks++;
    if (step_rel != 34) begin
      errors++;
      $display("FAIL basic_step_cycle: got=%0d required=34", step_rel);
    end
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_busy: got=%b required=0", busy);
    end
    quiesce();
  endtask

  task automatic test_averaging;
    bit got;
    vq = '{12'd100, 12'd200, 12'd300, 12'd400};
    iq = '{12'd1, 12'd1, 12'd1, 12'd2};
    sb.push_back('{v: 12'd250, i: 12'd1});
    enable = 1'b1;
    run_until_step(80, got);
    enable = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL avg_step_timeout: got no step, required one"); end
    quiesce();
    vq = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    iq = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    sb.push_back('{v: 12'hFFF, i: 12'hFFF});
    enable = 1'b1;
    run_until_step(80, got);
    enable = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL fullscale_step_timeout: got no step, required one"); end
    quiesce();
  endtask

  task automatic test_ack_settle;
    bit got;
    settle_cycles = 16'd10;
    ack_delay = 5;
    sb.push_back('{v: def_v, i: def_i});
    enable = 1'b1;
    run_until_step(80, got);
    checks++;
    if (!got) begin errors++; $display("FAIL ack_step_timeout: got no step, required one"); end
    ack_delay = 0;
    wait_start(60, got);
    checks++;
    if (!got || last_start_cyc - ack_cyc != 12) begin
      errors++;
      $display("FAIL delayed_ack_restart: got=%0d cycles (seen=%0d) required=12", last_start_cyc - ack_cyc, got);
    end
    sb.push_back('{v: def_v, i: def_i});
    run_until_step(80, got);
    wait_start(60, got);
    checks++;
    if (!got || last_start_cyc - last_step_cyc != 12) begin
      errors++;
      $display("FAIL step_ack_restart: got=%0d cycles (seen=%0d) required=12", last_start_cyc - last_step_cyc, got);
    end
    quiesce();
    settle_cycles = 16'd0;
  endtask

  task automatic test_timeout;
    bit got, seen;
    int s, ecyc, base_s, base_p;
    adc_on = 1'b0;
    base_p = step_count;
    enable = 1'b1;
    wait_start(20, got);
    s = last_start_cyc;
    seen = 1'b0; ecyc = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (error === 1'b1) begin seen = 1'b1; ecyc = cyc; break; end
    end
    checks++;
    if (!seen || ecyc - s != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_latency: got=%0d (seen=%0d) required=%0d", ecyc - s, seen, TIMEOUT + 1);
    end
    base_s = start_count;
    repeat (5) tick();
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || start_count != base_s || step_count != base_p) begin
      errors++;
      $display("FAIL timeout_sticky: error=%b busy=%b new_starts=%0d steps=%0d required 1/0/0/0",
               error, busy, start_count - base_s, step_count - base_p);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL error_clear: got=%b required=0", error); end
    adc_on = 1'b1;
    sb.push_back('{v: def_v, i: def_i});
    enable = 1'b1;
    run_until_step(80, got);
    checks++;
    if (!got) begin errors++; $display("FAIL timeout_recover: got no step, required one"); end
    quiesce();
  endtask

  task automatic test_disable_mid_round;
    bit got;
    int base_s, base_p;
    logic [ADC_W-1:0] old_v, old_i;
    old_v = held_v;
    old_i = held_i;
    settle_cycles = 16'd2;
    vq = '{12'd111, 12'd222};
    iq = '{12'd5, 12'd7};
    base_s = start_count;
    base_p = step_count;
    enable = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (start_count - base_s == 4) begin got = 1'b1; break; end
    end
    enable = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL abort_reach: starts=%0d required=4", start_count - base_s); end
    repeat (10) tick();
    checks++;
    if (step_count != base_p || busy !== 1'b0 || v_avg !== old_v || i_avg !== old_i) begin
      errors++;
      $display("FAIL abort_state: steps=%0d busy=%b v_avg=%0d i_avg=%0d required 0/0/%0d/%0d",
               step_count - base_p, busy, v_avg, i_avg, old_v, old_i);
    end
    vq = '{12'd1000, 12'd1000, 12'd1000, 12'd1000};
    iq = '{12'd40, 12'd40, 12'd40, 12'd40};
    sb.push_back('{v: 12'd1000, i: 12'd40});
    enable = 1'b1;
    wait_start(20, got);
    checks++;
    if (!got || v_avg !== old_v || i_avg !== old_i) begin
      errors++;
      $display("FAIL avg_hold: v_avg=%0d i_avg=%0d (started=%0d) required %0d/%0d", v_avg, i_avg, got, old_v, old_i);
    end
    run_until_step(80, got);
    checks++;
    if (!got) begin errors++; $display("FAIL fresh_round: got no step, required one"); end
    quiesce();
    settle_cycles = 16'd0;
  endtask

  task automatic test_async_reset;
    bit got;
    adc_on = 1'b0;
    enable = 1'b1;
    wait_start(20, got);
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || v_avg === '0) begin
      errors++;
      $display("FAIL pre_reset: busy=%b v_avg=%0d required busy=1 and nonzero v_avg", busy, v_avg);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({adc_start, adc_ch, mppt_step, error, busy} !== 5'b0 || v_avg !== '0 || i_avg !== '0) begin
      errors++;
      $display("FAIL async_reset: ctrl=%b v_avg=%0d i_avg=%0d required 00000/0/0",
               {adc_start, adc_ch, mppt_step, error, busy}, v_avg, i_avg);
    end
    enable = 1'b0;
    tick();
    rst = 1'b0;
    adc_on = 1'b1;
    quiesce();
  endtask

  initial begin
    test_reset();
    test_basic_round();
    test_averaging();
    test_ack_settle();
    test_timeout();
    test_disable_mid_round();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
